// File: rtl/rr_arbiter.sv
// Eight-way round-robin arbiter: rotating-priority pick in IDLE, registered one-hot grant
// held until done, request drop, or MAX_HOLD cycles elapse.
module rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [CW-1:0]   hold_cnt;
  logic [CW-1:0]   hold_cnt_nxt;
  logic [N-1:0]    gnt_nxt;
  logic [IW-1:0]   gnt_id_nxt;
  logic            gnt_valid_nxt;
  logic            timeout_nxt;

  logic [IW-1:0]   sel;
  logic            sel_found;
  logic [IW-1:0]   idx;
  logic            explicit_rel;
  logic            hold_hit;
  logic            rel_due;

  // Rotating-priority scan: start at ptr, ascend, wrap 7->0; first set bit wins.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ptr + IW'(k);
      if (!sel_found && req[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  // Explicit release (done or request drop) takes precedence over the hold limit for timeout.
  always_comb begin
    explicit_rel = done | ~req[gnt_id];
    hold_hit     = (hold_cnt == HOLD_LAST);
    rel_due      = explicit_rel | hold_hit;
  end

  // Next-state and next-output computation.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_cnt_nxt  = hold_cnt;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (sel_found) begin
          gnt_nxt       = N'(1) << sel;
          gnt_id_nxt    = sel;
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = '0;
          ptr_nxt       = sel + IW'(1);
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (rel_due) begin
          gnt_nxt       = '0;
          gnt_id_nxt    = '0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
          timeout_nxt   = ~explicit_rel;
          state_nxt     = IDLE;
        end else begin
          hold_cnt_nxt  = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a cycle-level owner/priority model predicts every
// post-edge output; a monitor pops and compares after each rising edge.
module tb_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       v;
    logic       to;
    logic [2:0] ptr;
  } exp_t;

  exp_t q[$];
  int   glog[$];
  int   total = 0;
  int   pass  = 0;

  // Model state: who owns the resource (-1 = nobody), next priority index, cycles held.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  bit   m_to    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act === exp_v) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  task automatic model(input bit r, input logic [7:0] rq, input bit d);
    exp_t e;
    int   c;
    bit   ex;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int i = 0; i < 8; i++) begin
        c = (m_ptr + i) % 8;
        if (m_owner < 0 && rq[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_ptr  = (m_owner + 1) % 8;
        m_held = 1;
      end
    end else begin
      ex = d || !rq[m_owner];
      if (ex || m_held == MH) begin
        m_to    = !ex;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
        m_to = 0;
      end
    end
    e.gnt = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    e.id  = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    e.v   = (m_owner >= 0);
    e.to  = m_to;
    e.ptr = 3'(m_ptr);
    q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [7:0] rq, input bit d);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    model(r, rq, d);
  endtask

  // Monitor: one expected entry per stimulated edge, plus a log of granted ids.
  initial begin
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt",       int'(gnt),       int'(e.gnt));
        chk("gnt_id",    int'(gnt_id),    int'(e.id));
        chk("gnt_valid", int'(gnt_valid), int'(e.v));
        chk("timeout",   int'(timeout),   int'(e.to));
        chk("ptr",       int'(dut.ptr),   int'(e.ptr));
      end
      if (gnt_valid === 1'b1 && prev_v !== 1'b1) glog.push_back(int'(gnt_id));
      prev_v = gnt_valid;
    end
  end

  initial begin
    logic [7:0] rq;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset then single request to 2, done on the third busy cycle.
    step(1, 8'h00, 0);
    step(1, 8'h00, 0);
    step(0, 8'h04, 0);
    step(0, 8'h04, 0);
    step(0, 8'h04, 0);
    step(0, 8'h04, 1);
    step(0, 8'h00, 0);

    // Rotation fairness from ptr=0 with all requesters active.
    step(1, 8'h00, 0);
    glog.delete();
    for (int i = 0; i < 9; i++) begin
      step(0, 8'hFF, 0);
      step(0, 8'hFF, 1);
    end
    @(posedge clk);
    #2;
    chk("rot_len", glog.size(), 9);
    for (int i = 0; i < 9 && i < glog.size(); i++) chk("rot_id", glog[i], i % 8);

    // Wrap-around: grant to 6 leaves ptr=7, then 0 beats 6.
    step(1, 8'h00, 0);
    step(0, 8'h40, 0);
    step(0, 8'h40, 1);
    step(0, 8'h41, 0);
    step(0, 8'h41, 1);
    step(0, 8'h00, 0);

    // Hold-limit release and regrant after one idle cycle.
    for (int i = 0; i < 12; i++) step(0, 8'h08, 0);
    step(0, 8'h00, 0);

    // Idle-time done ignored; request drop releases without timeout.
    step(0, 8'h00, 1);
    step(0, 8'h20, 0);
    step(0, 8'h20, 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    // Reset mid-grant, then lowest-index-first.
    step(0, 8'h10, 0);
    step(0, 8'h10, 0);
    step(1, 8'h12, 1);
    step(0, 8'h12, 0);
    step(0, 8'h12, 1);

    // Randomized traffic with sticky requests so the hold limit is exercised.
    rq = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        rq = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      step(($urandom_range(0, 63) == 0), rq, ($urandom_range(0, 4) == 0));
    end
    step(0, 8'h00, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
